// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Four-channel byte arbiter in front of a single UART transmitter.
// Each channel has a one-byte holding slot; slots are served round-robin.
module uart_tx_arbiter #(
  parameter logic [19:0] TIMEOUT = 20'd1000000,
  parameter int          TOW     = 20
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [3:0]  i_Req,
  input  logic [31:0] i_Data,
  input  logic        i_fReady,
  input  logic        i_fDoneTX,
  output logic        o_fTx,
  output logic [7:0]  o_TxData,
  output logic [3:0]  o_Full,
  output logic [3:0]  o_Grant,
  output logic [3:0]  o_Drop,
  output logic        o_Err,
  output logic        o_State
);

  // Handshake: i_Req[k] is a one-cycle offer, taken if the slot is empty or
  // being granted; i_fReady gates a start, o_fTx starts, i_fDoneTX ends a send.
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 20'd1);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_full;
  logic [3:0]      r_drop;
  logic [3:0]      r_grant;
  logic [3:0][7:0] r_hold;
  logic [1:0]      r_last;
  logic [TOW-1:0]  r_cnt;
  logic            r_ftx;
  logic            r_err;
  logic [7:0]      r_txdata;

  logic [1:0]      w_win;
  logic [1:0]      w_idx;
  logic            w_fire;
  logic            w_cnt_last;
  logic            w_abort;
  logic [3:0]      w_grant_vec;

  // Scan from farthest to nearest so the first full channel after r_last wins.
  always_comb begin
    w_win = r_last + 2'd1;
    w_idx = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      w_idx = r_last + 2'(i);
      if (r_full[w_idx]) w_win = w_idx;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fire) w_next = ST_SEND;
      ST_SEND: if (i_fDoneTX || w_cnt_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_fire      = (r_state == ST_IDLE) && (|r_full) && i_fReady;
    w_grant_vec = w_fire ? (4'b0001 << w_win) : 4'b0000;
    w_cnt_last  = (r_cnt == TO_LAST);
    w_abort     = (r_state == ST_SEND) && !i_fDoneTX && w_cnt_last;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_full   <= 4'b0000;
      r_drop   <= 4'b0000;
      r_grant  <= 4'b0000;
      r_hold   <= '0;
      r_last   <= 2'd3;
      r_cnt    <= '0;
      r_ftx    <= 1'b0;
      r_err    <= 1'b0;
      r_txdata <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (i_Req[k] && (!r_full[k] || w_grant_vec[k])) begin
          r_hold[k] <= i_Data[8*k +: 8];
          r_full[k] <= 1'b1;
        end else if (w_grant_vec[k]) begin
          r_full[k] <= 1'b0;
        end
        if (i_Req[k] && r_full[k] && !w_grant_vec[k]) r_drop[k] <= 1'b1;
      end
      r_ftx   <= w_fire;
      r_grant <= w_grant_vec;
      if (w_fire) begin
        r_txdata <= r_hold[w_win];
        r_last   <= w_win;
        r_cnt    <= '0;
      end else if (r_state == ST_SEND) begin
        r_cnt <= r_cnt + TOW'(1);
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign o_fTx    = r_ftx;
  assign o_TxData = r_txdata;
  assign o_Full   = r_full;
  assign o_Grant  = r_grant;
  assign o_Drop   = r_drop;
  assign o_Err    = r_err;
  assign o_State  = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run
// against a slot-level reference model.
module tb_uart_tx_arbiter;

  logic        i_Clk;
  logic        i_Rst;
  logic [3:0]  i_Req;
  logic [31:0] i_Data;
  logic        i_fReady;
  logic        i_fDoneTX;
  logic        o_fTx;
  logic [7:0]  o_TxData;
  logic [3:0]  o_Full;
  logic [3:0]  o_Grant;
  logic [3:0]  o_Drop;
  logic        o_Err;
  logic        o_State;

  int checks = 0;
  int errors = 0;
  bit tx_auto = 0;
  int tx_cnt = 0;
  logic [9:0] exp_q[$];

  uart_tx_arbiter #(.TIMEOUT(20'd16), .TOW(20)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Data(i_Data),
    .i_fReady(i_fReady), .i_fDoneTX(i_fDoneTX), .o_fTx(o_fTx),
    .o_TxData(o_TxData), .o_Full(o_Full), .o_Grant(o_Grant),
    .o_Drop(o_Drop), .o_Err(o_Err), .o_State(o_State)
  );

  // clock / reset
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; inputs set before the call land on this edge, outputs are
  // sampled 1ns after it. The transmitter model answers 5 cycles after a start.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    if (tx_auto) begin
      i_fDoneTX = 1'b0;
      if (o_fTx) tx_cnt = 4;
      else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) i_fDoneTX = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    i_Rst = 1'b0; i_Req = 4'h0; i_Data = 32'h0; i_fReady = 1'b0; i_fDoneTX = 1'b0;
    tx_cnt = 0;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst = 1'b1;
  endtask

  task automatic test_reset();
    i_Rst = 1'b0; i_Req = 4'h0; i_Data = 32'h0; i_fReady = 1'b0; i_fDoneTX = 1'b0;
    repeat (2) @(posedge i_Clk);
    #1;
    checks++; if (o_fTx !== 1'b0) begin errors++; $display("FAIL reset_ftx got %0b want 0", o_fTx); end
    checks++; if (o_TxData !== 8'h00) begin errors++; $display("FAIL reset_txdata got %h want 00", o_TxData); end
    checks++; if (o_Full !== 4'h0) begin errors++; $display("FAIL reset_full got %b want 0000", o_Full); end
    checks++; if (o_Grant !== 4'h0) begin errors++; $display("FAIL reset_grant got %b want 0000", o_Grant); end
    checks++; if (o_Drop !== 4'h0) begin errors++; $display("FAIL reset_drop got %b want 0000", o_Drop); end
    checks++; if (o_Err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", o_Err); end
    checks++; if (o_State !== 1'b0) begin errors++; $display("FAIL reset_state got %0b want 0", o_State); end
    i_Rst = 1'b1;
  endtask

  task automatic test_single();
    i_fReady = 1'b1;
    i_Req = 4'b0010; i_Data = 32'h0000_A500;
    tick();
    i_Req = 4'h0;
    checks++; if (o_Full !== 4'b0010) begin errors++; $display("FAIL single_full got %b want 0010", o_Full); end
    checks++; if (o_fTx !== 1'b0) begin errors++; $display("FAIL single_early_ftx got %0b want 0", o_fTx); end
    tick();
    checks++; if (o_fTx !== 1'b1) begin errors++; $display("FAIL single_ftx got %0b want 1", o_fTx); end
    checks++; if (o_Grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", o_Grant); end
    checks++; if (o_TxData !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", o_TxData); end
    checks++; if (o_Full !== 4'b0000) begin errors++; $display("FAIL single_full_clr got %b want 0000", o_Full); end
    tick();
    checks++; if (o_fTx !== 1'b0 || o_Grant !== 4'h0) begin errors++; $display("FAIL single_pulse_len ftx %0b grant %b want 0 0000", o_fTx, o_Grant); end
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
    checks++; if (o_State !== 1'b0) begin errors++; $display("FAIL single_done_idle got %0b want 0", o_State); end
  endtask

  task automatic test_back_to_back();
    i_fReady = 1'b0;
    i_Req = 4'b0101; i_Data = 32'h0022_0020;
    tick();
    i_Req = 4'h0;
    repeat (3) tick();
    checks++; if (o_fTx !== 1'b0 || o_Full !== 4'b0101) begin errors++; $display("FAIL b2b_hold ftx %0b full %b want 0 0101", o_fTx, o_Full); end
    i_fReady = 1'b1;
    tick();
    checks++; if (o_Grant !== 4'b0100 || o_TxData !== 8'h22) begin errors++; $display("FAIL b2b_first grant %b data %h want 0100 22", o_Grant, o_TxData); end
    tick(); tick();
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
    checks++; if (o_fTx !== 1'b0 || o_State !== 1'b0) begin errors++; $display("FAIL b2b_gap ftx %0b state %0b want 0 0", o_fTx, o_State); end
    tick();
    checks++; if (o_fTx !== 1'b1 || o_Grant !== 4'b0001 || o_TxData !== 8'h20) begin errors++; $display("FAIL b2b_second ftx %0b grant %b data %h want 1 0001 20", o_fTx, o_Grant, o_TxData); end
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [9:0] e;
    do_reset();
    tx_auto = 1'b1; i_fReady = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        i_Req = 4'hF; i_Data = 32'h1312_1110;
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 8'(8'h10 + k)});
      end else begin
        i_Req = 4'b1001; i_Data = 32'h2300_0020;
        exp_q.push_back({2'd0, 8'h20});
        exp_q.push_back({2'd3, 8'h23});
      end
      tick();
      i_Req = 4'h0;
      for (int c = 0; c < 100; c++) begin
        if (o_fTx) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rr_extra grant %b data %h want none", o_Grant, o_TxData);
          end else begin
            e = exp_q.pop_front();
            if (o_Grant !== (4'b0001 << e[9:8]) || o_TxData !== e[7:0]) begin
              errors++; $display("FAIL rr_order grant %b data %h want ch%0d %h", o_Grant, o_TxData, e[9:8], e[7:0]);
            end
          end
        end else begin
          checks++; if (o_Grant !== 4'h0) begin errors++; $display("FAIL rr_grant_idle got %b want 0000", o_Grant); end
        end
        if (exp_q.size() == 0 && o_State == 1'b0) break;
        tick();
      end
      checks++; if (exp_q.size() != 0 || o_State !== 1'b0) begin errors++; $display("FAIL rr_drain left %0d state %0b want 0 0", exp_q.size(), o_State); end
      exp_q.delete();
    end
    tx_auto = 1'b0; i_fDoneTX = 1'b0;
  endtask

  task automatic test_overflow();
    i_fReady = 1'b0;
    i_Req = 4'b0100; i_Data = 32'h0001_0000; tick();
    i_Req = 4'b0100; i_Data = 32'h0002_0000; tick();
    i_Req = 4'h0;
    checks++; if (o_Drop !== 4'b0100 || o_Full !== 4'b0100) begin errors++; $display("FAIL ovf_drop drop %b full %b want 0100 0100", o_Drop, o_Full); end
    i_fReady = 1'b1; i_Req = 4'b0100; i_Data = 32'h0003_0000;
    tick();
    i_Req = 4'h0;
    checks++; if (o_Grant !== 4'b0100 || o_TxData !== 8'h01) begin errors++; $display("FAIL ovf_first grant %b data %h want 0100 01", o_Grant, o_TxData); end
    checks++; if (o_Full !== 4'b0100 || o_Drop !== 4'b0100) begin errors++; $display("FAIL ovf_restore full %b drop %b want 0100 0100", o_Full, o_Drop); end
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
    tick();
    checks++; if (o_fTx !== 1'b1 || o_Grant !== 4'b0100 || o_TxData !== 8'h03) begin errors++; $display("FAIL ovf_second ftx %0b grant %b data %h want 1 0100 03", o_fTx, o_Grant, o_TxData); end
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    i_fReady = 1'b0;
    i_Req = 4'b0011; i_Data = 32'h0000_6655; tick();
    i_Req = 4'h0; i_fReady = 1'b1;
    tick();
    checks++; if (o_Grant !== 4'b0001 || o_TxData !== 8'h55) begin errors++; $display("FAIL to_start grant %b data %h want 0001 55", o_Grant, o_TxData); end
    checks++; if (o_Err !== 1'b0) begin errors++; $display("FAIL to_err_early got %0b want 0", o_Err); end
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_State == 1'b0) begin k = c; break; end
    end
    checks++; if (k != 16) begin errors++; $display("FAIL to_cycles got %0d want 16", k); end
    checks++; if (o_Err !== 1'b1) begin errors++; $display("FAIL to_err got %0b want 1", o_Err); end
    tick();
    checks++; if (o_fTx !== 1'b1 || o_Grant !== 4'b0010 || o_TxData !== 8'h66) begin errors++; $display("FAIL to_next ftx %0b grant %b data %h want 1 0010 66", o_fTx, o_Grant, o_TxData); end
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
    checks++; if (o_Err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %0b want 1", o_Err); end
  endtask

  task automatic test_reset_mid_send();
    int seen;
    i_fReady = 1'b0;
    i_Req = 4'hF; i_Data = 32'h3332_3130; tick();
    i_Req = 4'h0; i_fReady = 1'b1;
    tick();
    checks++; if (o_fTx !== 1'b1 || o_Full !== 4'b1011) begin errors++; $display("FAIL rms_setup ftx %0b full %b want 1 1011", o_fTx, o_Full); end
    #3;
    i_Rst = 1'b0;
    #1;
    checks++;
    if (o_fTx !== 1'b0 || o_TxData !== 8'h00 || o_Full !== 4'h0 || o_Grant !== 4'h0 ||
        o_Drop !== 4'h0 || o_Err !== 1'b0 || o_State !== 1'b0) begin
      errors++;
      $display("FAIL rms_async ftx %0b data %h full %b grant %b drop %b err %0b state %0b want all 0",
               o_fTx, o_TxData, o_Full, o_Grant, o_Drop, o_Err, o_State);
    end
    tick(); tick();
    i_Rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_fTx !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rms_no_ftx got %0d pulses want 0", seen); end
    i_Req = 4'b0010; i_Data = 32'h0000_7700; tick();
    i_Req = 4'h0; tick();
    checks++; if (o_fTx !== 1'b1 || o_Grant !== 4'b0010 || o_TxData !== 8'h77) begin errors++; $display("FAIL rms_resume ftx %0b grant %b data %h want 1 0010 77", o_fTx, o_Grant, o_TxData); end
    i_fDoneTX = 1'b1; tick(); i_fDoneTX = 1'b0;
  endtask

  // Reference model: four slots, a last-granted index, and a busy flag.
  task automatic test_random();
    bit         m_idle;
    int         m_last;
    logic [3:0] m_full, m_drop, req, exp_g;
    logic [7:0] m_data[4];
    logic [7:0] m_tx;
    logic [31:0] dat;
    bit         fire;
    int         win, c;
    do_reset();
    m_idle = 1; m_last = 3; m_full = 0; m_drop = 0; m_tx = 8'h00;
    for (int k = 0; k < 4; k++) m_data[k] = 8'h00;
    tx_auto = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req = 4'h0;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) req[k] = 1'b1;
      dat = $urandom;
      i_Req = req; i_Data = dat; i_fReady = ($urandom_range(0, 4) != 0);
      fire = m_idle && (m_full != 0) && i_fReady;
      win = -1;
      for (int off = 1; off <= 4; off++) begin
        c = (m_last + off) % 4;
        if (win < 0 && m_full[c]) win = c;
      end
      exp_g = fire ? 4'(1 << win) : 4'h0;
      if (fire) begin m_tx = m_data[win]; m_last = win; end
      for (int k = 0; k < 4; k++) begin
        if (req[k]) begin
          if (!m_full[k] || (fire && win == k)) begin m_data[k] = dat[8*k +: 8]; m_full[k] = 1'b1; end
          else m_drop[k] = 1'b1;
        end else if (fire && win == k) m_full[k] = 1'b0;
      end
      if (fire) m_idle = 0;
      else if (!m_idle && i_fDoneTX) m_idle = 1;
      tick();
      i_Req = 4'h0;
      checks++; if (o_fTx !== fire) begin errors++; $display("FAIL rnd_ftx cyc %0d got %0b want %0b", cyc, o_fTx, fire); end
      checks++; if (o_Grant !== exp_g) begin errors++; $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, o_Grant, exp_g); end
      checks++; if (o_TxData !== m_tx) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, o_TxData, m_tx); end
      checks++; if (o_Full !== m_full) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %b", cyc, o_Full, m_full); end
      checks++; if (o_Drop !== m_drop) begin errors++; $display("FAIL rnd_drop cyc %0d got %b want %b", cyc, o_Drop, m_drop); end
      checks++; if (o_State !== !m_idle) begin errors++; $display("FAIL rnd_state cyc %0d got %0b want %0b", cyc, o_State, !m_idle); end
    end
    tx_auto = 1'b0; i_fDoneTX = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
